// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory and its dump sequencer.
//   dump_state_t   : dump FSM encoding (IDLE, DUMP, DONE)
//   N_DEFAULT      : default data word width in bits
//   DEPTH_DEFAULT  : default number of words
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } dump_state_t;

    localparam int N_DEFAULT     = 64;
    localparam int DEPTH_DEFAULT = 64;

endpackage

// File: rtl/dmem_dump_seq.sv
// Dump sequencer: walks word indices 0..DEPTH-1 over a valid/ready port.
// The parent owns the memory array and supplies data for dump_index.
//   clk, rst_n          : clock, asynchronous active-low reset
//   dump                : level request; a new sequence starts on its rising edge
//   dump_ready          : consumer accepts the current beat
//   dump_valid          : beat present (registered)
//   dump_index          : word index of the current beat (registered)
//   dump_done           : sequence finished, held until dump drops (registered)
module dmem_dump_seq
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dump,
    input  logic          dump_ready,
    output logic          dump_valid,
    output logic [AW-1:0] dump_index,
    output logic          dump_done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    dump_state_t   state_q, state_d;
    logic          dump_q, dump_d;
    logic [AW-1:0] index_q, index_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;

    always_comb begin
        state_d = state_q;
        dump_d  = dump;
        index_d = index_q;
        valid_d = valid_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                if (dump && !dump_q) begin
                    state_d = DUMP;
                    index_d = '0;
                    valid_d = 1'b1;
                end
            end
            DUMP: begin
                // dump is not looked at here: dropping it does not abort.
                if (valid_q && dump_ready) begin
                    if (index_q == LAST_IDX) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end
            end
            DONE: begin
                // Leaving only on dump=0 means a held-high request cannot
                // retrigger; dump_q then sees 0 so the next rise is caught.
                if (!dump) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dump_q  <= 1'b0;
            index_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dump_q  <= dump_d;
            index_q <= index_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign dump_valid = valid_q;
    assign dump_index = index_q;
    assign dump_done  = done_q;

endmodule

// File: rtl/data_memory_dump.sv
// Word-addressed data memory for the single-cycle core with a dump port
// that streams every word out over valid/ready for end-of-run snapshots.
//   CLOCK_50, reset        : clock, asynchronous active-low reset
//   DM_addr                : byte address; word index is DM_addr[AW+2:3]
//   DM_writeData/Enable    : store data and strobe (rising edge)
//   DM_readData            : combinational load data, 0 when out of range
//   dump, dump_ready       : dump request (rising edge) and beat accept
//   dump_valid/index/data  : current dump beat
//   dump_done              : dump sequence complete
//   dm_err                 : sticky out-of-range store flag
// Build option: define DMEM_ALIGN_CHECK_EN to also flag any edge with a
// non-zero DM_addr[2:0] in dm_err (the store still commits).
module data_memory_dump
    import dmem_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic [N-1:0]             DM_addr,
    input  logic [N-1:0]             DM_writeData,
    input  logic                     DM_writeEnable,
    output logic [N-1:0]             DM_readData,
    input  logic                     dump,
    input  logic                     dump_ready,
    output logic                     dump_valid,
    output logic [$clog2(DEPTH)-1:0] dump_index,
    output logic [N-1:0]             dump_data,
    output logic                     dump_done,
    output logic                     dm_err
);

    localparam int AW = $clog2(DEPTH);

    logic [N-1:0]  mem_q [DEPTH];
    logic [N-1:0]  mem_d [DEPTH];
    logic          dm_err_q, dm_err_d;

    // Word address: byte offset dropped, top bits must be zero to be in range.
    logic [N-4:0]  word_addr;
    logic [AW-1:0] word_idx;
    logic          in_range;
    logic          misaligned;

    assign word_addr = (N-3)'(DM_addr >> 3);
    assign word_idx  = word_addr[AW-1:0];
    assign in_range  = ~|word_addr[N-4:AW];

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = |DM_addr[2:0];
`else
    assign misaligned = 1'b0;
`endif

    assign DM_readData = in_range ? mem_q[word_idx] : '0;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (DM_writeEnable && in_range) begin
            mem_d[word_idx] = DM_writeData;
        end
        dm_err_d = dm_err_q | (DM_writeEnable && !in_range) | misaligned;
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            dm_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            dm_err_q <= dm_err_d;
        end
    end

    assign dm_err = dm_err_q;

    dmem_dump_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dump_seq (
        .clk        (CLOCK_50),
        .rst_n      (reset),
        .dump       (dump),
        .dump_ready (dump_ready),
        .dump_valid (dump_valid),
        .dump_index (dump_index),
        .dump_done  (dump_done)
    );

    // Read straight from the pre-edge array, so a beat that transfers on the
    // same edge as a store to its index carries the old word.
    assign dump_data = mem_q[dump_index];

endmodule

// File: tb/tb_data_memory_dump.sv
module tb_data_memory_dump;

    localparam int N     = 64;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic [N-1:0]  DM_addr;
    logic [N-1:0]  DM_writeData;
    logic          DM_writeEnable;
    logic [N-1:0]  DM_readData;
    logic          dump;
    logic          dump_ready;
    logic          dump_valid;
    logic [AW-1:0] dump_index;
    logic [N-1:0]  dump_data;
    logic          dump_done;
    logic          dm_err;

    data_memory_dump #(.N(N), .DEPTH(DEPTH)) dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .DM_addr        (DM_addr),
        .DM_writeData   (DM_writeData),
        .DM_writeEnable (DM_writeEnable),
        .DM_readData    (DM_readData),
        .dump           (dump),
        .dump_ready     (dump_ready),
        .dump_valid     (dump_valid),
        .dump_index     (dump_index),
        .dump_data      (dump_data),
        .dump_done      (dump_done),
        .dm_err         (dm_err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Reference model: plain word array plus sticky error bit.
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [N-1:0] mdl [DEPTH];
    bit           mdl_err;
    int           exp_idx;
    int           beats;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] mdl_read(input logic [N-1:0] a);
        if (a < DEPTH * 8) return mdl[a[AW+2:3]];
        return '0;
    endfunction

    task automatic mdl_clear();
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        mdl_err = 0;
    endtask

    // One clock: check the current beat, cross the edge, update the model.
    task automatic tick();
        bit            stalled;
        logic [AW-1:0] held;
        #1;
        stalled = 0;
        held    = '0;
        if (dump_valid) check("beat_data", dump_data, mdl[dump_index]);
        if (dump_valid && dump_ready) begin
            check("beat_index", N'(dump_index), N'(exp_idx));
            exp_idx++;
            beats++;
        end else if (dump_valid) begin
            stalled = 1;
            held    = dump_index;
        end
        @(posedge CLOCK_50);
        if (DM_writeEnable) begin
            if (DM_addr < DEPTH * 8) mdl[DM_addr[AW+2:3]] = DM_writeData;
            else mdl_err = 1;
        end
        #1;
        if (stalled) begin
            check("stall_valid", N'(dump_valid), 1);
            check("stall_index", N'(dump_index), N'(held));
        end
        check("dm_err", N'(dm_err), N'(mdl_err));
    endtask

    task automatic rd_chk(input logic [N-1:0] a);
        DM_addr = a;
        #1;
        check("read", DM_readData, mdl_read(a));
    endtask

    task automatic start_dump();
        dump = 0;
        tick();
        tick();
        exp_idx = 0;
        beats   = 0;
        dump    = 1;
    endtask

    // mode 0: ready held high; mode 1: ready toggles, random stores mixed in.
    task automatic run_until_done(input int bound, input int mode);
        for (int c = 0; c < bound && !dump_done; c++) begin
            if (mode == 1) begin
                dump_ready = (c % 2) == 1;
                DM_writeEnable = ($urandom % 3) == 0;
                DM_addr        = N'($urandom_range(0, DEPTH * 8 - 1));
                DM_writeData   = {$urandom, $urandom};
            end else begin
                dump_ready     = 1;
                DM_writeEnable = 0;
            end
            tick();
        end
        DM_writeEnable = 0;
        check("dump_done", N'(dump_done), 1);
        check("beat_count", N'(beats), N'(DEPTH));
    endtask

    initial begin
        logic [N-1:0] old_word;
        reset = 0; DM_addr = '0; DM_writeData = '0; DM_writeEnable = 0;
        dump = 0; dump_ready = 0; exp_idx = 0; beats = 0;
        mdl_clear();
        #12;
        check("rst_valid", N'(dump_valid), 0);
        check("rst_index", N'(dump_index), 0);
        check("rst_done", N'(dump_done), 0);
        check("rst_err", N'(dm_err), 0);
        rd_chk(64'h18);
        reset = 1;
        @(posedge CLOCK_50);
        #1;

        // Directed store and readback, low address bits ignored.
        DM_addr = 64'h18; DM_writeData = 64'hDEAD_BEEF_CAFE_F00D; DM_writeEnable = 1;
        tick();
        DM_writeEnable = 0;
        rd_chk(64'h18);
        rd_chk(64'h1F);
        check("direct_value", DM_readData, 64'hDEAD_BEEF_CAFE_F00D);

        // Random stores and loads, occasional wild addresses.
        for (int k = 0; k < 150; k++) begin
            DM_writeEnable = ($urandom % 2) == 1;
            if (($urandom % 10) == 0) DM_addr = {$urandom, $urandom};
            else DM_addr = N'($urandom_range(0, DEPTH * 8 - 1));
            DM_writeData = {$urandom, $urandom};
            tick();
            DM_writeEnable = 0;
            if (($urandom % 8) == 0) rd_chk({$urandom, $urandom});
            else rd_chk(N'($urandom_range(0, DEPTH * 8 - 1)));
        end

        // Fresh reset, then an out-of-range store.
        reset = 0;
        #2;
        mdl_clear();
        check("rst2_err", N'(dm_err), 0);
        rd_chk(64'h18);
        reset = 1;
        @(posedge CLOCK_50);
        #1;
        DM_addr = 64'h200; DM_writeData = 64'h1234_5678_9ABC_DEF0; DM_writeEnable = 1;
        tick();
        DM_writeEnable = 0;
        check("oor_err", N'(dm_err), 1);
        rd_chk(64'h200);
        rd_chk(64'h0);

        // Preload mem[i] = i*3 and dump with ready held high.
        for (int i = 0; i < DEPTH; i++) begin
            DM_addr = N'(i * 8); DM_writeData = N'(i * 3); DM_writeEnable = 1;
            tick();
        end
        DM_writeEnable = 0;
        start_dump();
        run_until_done(200, 0);
        check("done_valid_low", N'(dump_valid), 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hold_no_retrigger", N'(dump_valid), 0);
            check("hold_done", N'(dump_done), 1);
        end
        dump = 0;
        tick();
        check("done_clears", N'(dump_done), 0);

        // Backpressure with random stores during the dump.
        start_dump();
        run_until_done(400, 1);
        dump_ready = 1;

        // Store to the index transferring on the same edge.
        start_dump();
        for (int c = 0; c < 200 && !dump_done; c++) begin
            if (dump_valid && dump_index == 5) begin
                old_word = mdl[5];
                check("collision_old", dump_data, old_word);
                DM_addr = 64'h28; DM_writeData = 64'h55; DM_writeEnable = 1;
            end
            tick();
            DM_writeEnable = 0;
        end
        check("collision_done", N'(dump_done), 1);
        check("collision_beats", N'(beats), N'(DEPTH));
        rd_chk(64'h28);
        check("collision_commit", DM_readData, 64'h55);

        // Reset in the middle of a dump.
        start_dump();
        dump_ready = 1;
        for (int c = 0; c < 100 && !(dump_valid && dump_index == 20); c++) tick();
        check("reach_idx20", N'(dump_index), 20);
        reset = 0;
        #1;
        mdl_clear();
        check("mid_rst_valid", N'(dump_valid), 0);
        check("mid_rst_done", N'(dump_done), 0);
        check("mid_rst_index", N'(dump_index), 0);
        check("mid_rst_err", N'(dm_err), 0);
        for (int i = 0; i < DEPTH; i++) rd_chk(N'(i * 8));
        dump = 0;
        @(negedge CLOCK_50);
        reset = 1;
        @(posedge CLOCK_50);
        #1;
        start_dump();
        run_until_done(200, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_memory_dump.md
Name: data_memory_dump

Overview:
- 64-bit word data memory directly downstream of processor_arm's data-memory port; consumes DM_addr, DM_writeData and DM_writeEnable, and returns read data combinationally.
- Contains a dump sequencer. When dump is asserted, it streams every word out through a valid/ready port so the bench or a host can snapshot memory at end of run.
- Sits between the processor and the testbench/top level.

Parameters:
- N, 64, data word width in bits.
- DEPTH, 64, number of words; power of two, at least 2.
- AW, $clog2(DEPTH), word-index width (derived localparam).

Ports:
- CLOCK_50  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- DM_addr  input  N  byte address from processor.
- DM_writeData  input  N  store data.
- DM_writeEnable  input  1  store strobe, sampled on rising edge.
- DM_readData  output  N  load data, combinational.
- dump  input  1  dump request, level; acted on at its rising edge.
- dump_ready  input  1  consumer accepts the current dump beat.
- dump_valid  output  1  dump beat present.
- dump_index  output  AW  word index of current beat.
- dump_data  output  N  word contents of current beat.
- dump_done  output  1  dump sequence complete.
- dm_err  output  1  sticky out-of-range access flag.

Behaviour:
- Address decode
  - Word index = DM_addr[AW+2:3]; DM_addr[2:0] is ignored.
  - Address is in range iff DM_addr[N-1:AW+3] == 0.
- Reads
  - DM_readData = mem[index] when in range, else 0.
  - Purely combinational, zero latency, as the single-cycle datapath requires.
- Writes
  - mem[index] <= DM_writeData on a rising edge with DM_writeEnable=1 and address in range.
  - Out-of-range writes are dropped.
- Error flag
  - dm_err sets on any clock edge where DM_writeEnable=1 with an out-of-range address.
  - Cleared only by reset.
- Reset (reset=0, asynchronous)
  - All memory words = 0.
  - FSM = IDLE; dump_valid=0, dump_index=0, dump_done=0, dm_err=0.
  - Registered dump_q = 0.
- Dump FSM states: IDLE, DUMP, DONE.
  - IDLE: dump_q is dump delayed one cycle. On dump=1 && dump_q=0, go to DUMP with index=0. dump_valid goes high the next cycle (one-cycle latency).
  - DUMP: dump_valid=1, dump_data=mem[dump_index] (combinational from the array).
    - A beat transfers on a clock edge where dump_valid && dump_ready.
    - On transfer: index increments. If the index was DEPTH-1, go to DONE instead (no wrap).
    - With dump_ready=0, dump_index and dump_data hold stable, except when the processor writes the held index (see next rule).
  - DONE: dump_valid=0, dump_done=1. Stay until dump=0, then go to IDLE with dump_done=0.
  - A level-high dump held through DONE does not retrigger; a new rising edge is required.
  - Deasserting dump mid-DUMP does not abort the sequence.
- Simultaneous processor write and dump transfer of the same index
  - The beat carries the pre-write value (read-before-write).
  - The write still commits.
  - Subsequent beats see updated contents.
- Reset mid-DUMP
  - Immediate return to IDLE with outputs as listed under Reset.
  - Memory is cleared.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined:
  - Any access with DM_addr[2:0] != 0 also sets dm_err. This covers a write strobe, or a read, judged by the address being nonzero while DM_writeEnable=0, sampled each edge.
  - The write itself still commits to the truncated index.
- Undefined:
  - Low address bits are silently ignored.
  - dm_err reflects only out-of-range writes.

Decomposition:
- Shared package dmem_pkg holds:
  - typedef enum logic [1:0] {IDLE, DUMP, DONE} dump_state_t;
  - N_DEFAULT = 64 and DEPTH_DEFAULT = 64 constants.
- One natural sub-module: dmem_dump_seq. It holds the FSM, dump_q edge detect, index counter and done logic, and indexes the array owned by the parent.

Test Plan:
- Write/read: store 0xDEADBEEF_CAFEF00D at addr 0x18 -> DM_readData at addr 0x18 equals that value in the same cycle; addr 0x1F also returns it.
- Out-of-range: write with addr 0x200 (DEPTH=64) -> memory unchanged, DM_readData=0 at 0x200, dm_err=1 until reset.
- Full dump with dump_ready=1 constantly: preload mem[i]=i*3 -> 64 beats, index 0..63 with data i*3, then dump_done=1. Holding dump high leaves no second dump; dropping dump gives dump_done=0.
- Backpressure: dump_ready toggled 0/1 every cycle -> each index is presented until accepted, none skipped or duplicated, dump_data stable while stalled.
- Collision: on the beat index=5 transfer edge, processor writes 0x55 to addr 0x28 -> beat shows old value; a later DM_readData at 0x28 = 0x55.
- Reset mid-dump: assert reset=0 at index 20 -> dump_valid=0, dump_done=0, mem[0..63]=0 immediately. A new dump rising edge after release restarts at index 0.
